// File: rtl/tm_multiclass_controller.sv
// tm_multiclass_controller: multi-class Tsetlin Machine inference sequencer with start/done, stall and abort
module tm_multiclass_controller #(
  parameter  int CLAUSES       = 2000,
  parameter  int LA_CHUNKS     = 49,
  parameter  int CLAUSE_CHUNKS = 63,
  parameter  int CLASSES       = 10,
  localparam int CW = CLAUSES > 1 ? $clog2(CLAUSES) : 1,
  localparam int LW = LA_CHUNKS > 1 ? $clog2(LA_CHUNKS) : 1,
  localparam int KW = CLAUSE_CHUNKS > 1 ? $clog2(CLAUSE_CHUNKS) : 1,
  localparam int NW = CLASSES > 1 ? $clog2(CLASSES) : 1
) (
  input  logic          clk,
  input  logic          rst_flag_n,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic [CW-1:0] clause_id,
  output logic [LW-1:0] la_chunk_id,
  output logic [KW-1:0] clause_chunk_id,
  output logic [NW-1:0] class_id,
  output logic          compare_states_ctrl,
  output logic          clause_out_ctrl,
  output logic          class_sum_ctrl,
  output logic          class_sum_th_ctrl,
  output logic          argmax_en,
  output logic          write_mode,
  output logic          read_mode,
  output logic          busy,
  output logic          done_flag
);
  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_CLOSE, S_SUM, S_THRESH, S_ARGMAX, S_DONE} state_t;
  localparam logic [CW-1:0] CL_LAST = CW'(CLAUSES - 1);
  localparam logic [LW-1:0] LA_LAST = LW'(LA_CHUNKS - 1);
  localparam logic [KW-1:0] CK_LAST = KW'(CLAUSE_CHUNKS - 1);
  localparam logic [NW-1:0] CS_LAST = NW'(CLASSES - 1);
  state_t        r_state, w_nstate;
  logic [CW-1:0] r_clause, w_nclause;
  logic [LW-1:0] r_la, w_nla;
  logic [KW-1:0] r_chunk, w_nchunk;
  logic [NW-1:0] r_class, w_nclass;
  logic          r_go, w_go;
  // r_go marks a cycle whose action really executes; a stalled edge leaves a bubble with strobes idle
  always_ff @(posedge clk or negedge rst_flag_n)
    if (!rst_flag_n) begin
      r_state  <= S_IDLE;
      r_clause <= '0;
      r_la     <= '0;
      r_chunk  <= '0;
      r_class  <= '0;
      r_go     <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_clause <= w_nclause;
      r_la     <= w_nla;
      r_chunk  <= w_nchunk;
      r_class  <= w_nclass;
      r_go     <= w_go;
    end
  always_comb begin
    w_nstate  = r_state;
    w_nclause = r_clause;
    w_nla     = r_la;
    w_nchunk  = r_chunk;
    w_nclass  = r_class;
    w_go      = !abort && (r_state == S_IDLE || !stall);
    if (abort) begin
      w_nstate  = S_IDLE;
      w_nclause = '0;
      w_nla     = '0;
      w_nchunk  = '0;
      w_nclass  = '0;
    end else if (w_go) begin
      case (r_state)
        S_IDLE:   w_nstate = start ? S_EVAL : S_IDLE;
        S_EVAL: begin
          w_nla    = r_la == LA_LAST ? r_la : r_la + 1'b1;
          w_nstate = r_la == LA_LAST ? S_CLOSE : S_EVAL;
        end
        S_CLOSE: begin
          w_nla     = '0;
          w_nclause = r_clause == CL_LAST ? '0 : r_clause + 1'b1;
          w_nstate  = r_clause == CL_LAST ? S_SUM : S_EVAL;
        end
        S_SUM: begin
          w_nchunk = r_chunk == CK_LAST ? '0 : r_chunk + 1'b1;
          w_nstate = r_chunk == CK_LAST ? S_THRESH : S_SUM;
        end
        S_THRESH: w_nstate = S_ARGMAX;
        S_ARGMAX: begin
          w_nclass = r_class == CS_LAST ? r_class : r_class + 1'b1;
          w_nstate = r_class == CS_LAST ? S_DONE : S_EVAL;
        end
        S_DONE: begin
          w_nclass = '0;
          w_nstate = S_IDLE;
        end
        default: begin
          w_nstate  = S_IDLE;
          w_nclause = '0;
          w_nla     = '0;
          w_nchunk  = '0;
          w_nclass  = '0;
        end
      endcase
    end
  end
  always_comb begin
    compare_states_ctrl = !(r_go && r_state == S_EVAL);
    clause_out_ctrl     = !(r_go && r_state == S_CLOSE);
    class_sum_ctrl      = !(r_go && r_state == S_SUM);
    class_sum_th_ctrl   = !(r_go && r_state == S_THRESH);
    argmax_en           = r_go && r_state == S_ARGMAX;
    done_flag           = r_go && r_state == S_DONE;
    write_mode          = r_state == S_EVAL || r_state == S_CLOSE;
    read_mode           = r_state == S_SUM || r_state == S_THRESH;
    busy                = r_state != S_IDLE;
    clause_id           = r_clause;
    la_chunk_id         = r_la;
    clause_chunk_id     = r_chunk;
    class_id            = r_class;
  end
endmodule

// File: tb/tb_tm_multiclass_controller.sv
// tb_tm_multiclass_controller: directed and randomized checks of two sequencer instances against a step-sequence model
module tb_tm_multiclass_controller;
  logic clk = 1'b0, rst_flag_n = 1'b1, start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [1:0] a_cl;
  logic a_la, a_ck, a_cs, a_cmp, a_clo, a_sum, a_th, a_amx, a_wm, a_rm, a_busy, a_done;
  logic b_cl, b_la, b_ck, b_cs, b_cmp, b_clo, b_sum, b_th, b_amx, b_wm, b_rm, b_busy, b_done;
  logic [8:0] a_ctl, b_ctl;
  int a_cnt, b_cnt;
  int checks = 0, errors = 0;
  int pos [2] = '{-1, -1};
  bit go [2] = '{1'b0, 1'b0};
  bit chk_on = 1'b0;
  int e_ph, e_cl, e_la, e_ck, e_cs;
  int m_d0, m_d0b, m_d1, m_cmp, m_clo, m_sum, m_amx, m_nd, m_a0, m_a1;
  int st1 = 0, sl1 = 0, st2 = 0, sl2 = 0, ab = -10;
  bit hold = 1'b0;

  tm_multiclass_controller #(.CLAUSES(3), .LA_CHUNKS(2), .CLAUSE_CHUNKS(2), .CLASSES(2)) u_dut (
    .clk(clk), .rst_flag_n(rst_flag_n), .start(start), .abort(abort), .stall(stall),
    .clause_id(a_cl), .la_chunk_id(a_la), .clause_chunk_id(a_ck), .class_id(a_cs),
    .compare_states_ctrl(a_cmp), .clause_out_ctrl(a_clo), .class_sum_ctrl(a_sum),
    .class_sum_th_ctrl(a_th), .argmax_en(a_amx), .write_mode(a_wm), .read_mode(a_rm),
    .busy(a_busy), .done_flag(a_done));

  tm_multiclass_controller #(.CLAUSES(1), .LA_CHUNKS(1), .CLAUSE_CHUNKS(1), .CLASSES(1)) u_deg (
    .clk(clk), .rst_flag_n(rst_flag_n), .start(start), .abort(abort), .stall(stall),
    .clause_id(b_cl), .la_chunk_id(b_la), .clause_chunk_id(b_ck), .class_id(b_cs),
    .compare_states_ctrl(b_cmp), .clause_out_ctrl(b_clo), .class_sum_ctrl(b_sum),
    .class_sum_th_ctrl(b_th), .argmax_en(b_amx), .write_mode(b_wm), .read_mode(b_rm),
    .busy(b_busy), .done_flag(b_done));

  assign a_ctl = {a_cmp, a_clo, a_sum, a_th, a_amx, a_wm, a_rm, a_busy, a_done};
  assign b_ctl = {b_cmp, b_clo, b_sum, b_th, b_amx, b_wm, b_rm, b_busy, b_done};
  assign a_cnt = {6'b0, a_cl, 7'b0, a_la, 7'b0, a_ck, 7'b0, a_cs};
  assign b_cnt = {7'b0, b_cl, 7'b0, b_la, 7'b0, b_ck, 7'b0, b_cs};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // An inference is a flat list of steps; pos indexes it, -1 means idle
  function automatic int last_pos(input int k);
    return k ? 1 * (1 * (1 + 1) + 1 + 2) : 2 * (3 * (2 + 1) + 2 + 2);
  endfunction

  function automatic void decode(input int k, input int p, output int ph, output int cl,
                                 output int la, output int ck, output int cs);
    int ncl, nla, nck, ncs, ev, len, r;
    ncl = k ? 1 : 3;
    nla = k ? 1 : 2;
    nck = k ? 1 : 2;
    ncs = k ? 1 : 2;
    ev  = ncl * (nla + 1);
    len = ev + nck + 2;
    ph = 0; cl = 0; la = 0; ck = 0; cs = 0;
    if (p < 0) return;
    if (p == ncs * len) begin
      ph = 6;
      cs = ncs - 1;
      return;
    end
    cs = p / len;
    r  = p % len;
    if (r < ev) begin
      cl = r / (nla + 1);
      la = r % (nla + 1);
      ph = la < nla ? 1 : 2;
      if (la == nla) la = nla - 1;
    end else begin
      r -= ev;
      ph = r < nck ? 3 : (r == nck ? 4 : 5);
      ck = r < nck ? r : 0;
    end
  endfunction

  function automatic logic [8:0] exp_ctl(input int ph, input bit g);
    return {!(g && ph == 1), !(g && ph == 2), !(g && ph == 3), !(g && ph == 4), g && ph == 5,
            ph == 1 || ph == 2, ph == 3 || ph == 4, ph != 0, g && ph == 6};
  endfunction

  always @(posedge clk or negedge rst_flag_n)
    for (int k = 0; k < 2; k++)
      if (!rst_flag_n || abort) begin
        pos[k] <= -1;
        go[k]  <= 1'b0;
      end else if (pos[k] < 0) begin
        pos[k] <= start ? 0 : -1;
        go[k]  <= start;
      end else if (stall) go[k] <= 1'b0;
      else begin
        pos[k] <= pos[k] == last_pos(k) ? -1 : pos[k] + 1;
        go[k]  <= 1'b1;
      end

  always @(negedge clk)
    if (chk_on)
      for (int k = 0; k < 2; k++) begin
        decode(k, pos[k], e_ph, e_cl, e_la, e_ck, e_cs);
        chk($sformatf("d%0d_ctl", k), int'(k ? b_ctl : a_ctl), int'(exp_ctl(e_ph, go[k])));
        chk($sformatf("d%0d_cnt", k), k ? b_cnt : a_cnt, (e_cl << 24) | (e_la << 16) | (e_ck << 8) | e_cs);
      end

  task automatic run(input int n);
    m_d0 = 0; m_d0b = 0; m_d1 = 0; m_cmp = 0; m_clo = 0; m_sum = 0; m_amx = 0; m_nd = 0;
    m_a0 = -1; m_a1 = -1;
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!a_cmp) m_cmp++;
      if (!a_clo) m_clo++;
      if (!a_sum) m_sum++;
      if (a_amx) begin
        if (m_amx == 0) m_a0 = int'(a_cs);
        else m_a1 = int'(a_cs);
        m_amx++;
      end
      if (a_done) begin
        if (m_d0 == 0) m_d0 = c;
        else if (m_d0b == 0) m_d0b = c;
        m_nd++;
      end
      if (b_done && m_d1 == 0) m_d1 = c;
      if (c == ab + 1) begin
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_cnt", a_cnt, 0);
      end
      start = hold;
      stall = (c >= st1 && c < st1 + sl1) || (c >= st2 && c < st2 + sl2);
      abort = c == ab;
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #1 rst_flag_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_ctl", int'(a_ctl), int'(9'b111100000));
    chk("rst_cnt", a_cnt, 0);
    #2 rst_flag_n = 1'b1;
    @(negedge clk);
    run(40);
    chk("done_cycle", m_d0, 27);
    chk("deg_done_cycle", m_d1, 6);
    chk("done_pulses", m_nd, 1);
    chk("cmp_low", m_cmp, 12);
    chk("clo_low", m_clo, 6);
    chk("sum_low", m_sum, 4);
    chk("amx_high", m_amx, 2);
    chk("amx_class0", m_a0, 0);
    chk("amx_class1", m_a1, 1);
    st1 = 2; sl1 = 3; st2 = 13; sl2 = 2;
    run(45);
    st1 = 0; sl1 = 0; st2 = 0; sl2 = 0;
    chk("stall_done_cycle", m_d0, 32);
    chk("stall_cmp_low", m_cmp, 12);
    chk("stall_sum_low", m_sum, 4);
    chk("stall_amx_high", m_amx, 2);
    ab = 23;
    run(35);
    ab = -10;
    chk("abort_no_done", m_nd, 0);
    run(35);
    chk("restart_done_cycle", m_d0, 27);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_flag_n = 1'b0;
    #1;
    chk("async_busy", int'(a_busy), 0);
    chk("async_ctl", int'(a_ctl), int'(9'b111100000));
    chk("async_cnt", a_cnt, 0);
    chk("async_deg_busy", int'(b_busy), 0);
    @(negedge clk);
    #2 rst_flag_n = 1'b1;
    @(negedge clk);
    hold = 1'b1;
    run(60);
    hold = 1'b0;
    chk("held_done_cycle", m_d0, 27);
    chk("held_second_done", m_d0b, 55);
    start = 1'b1;
    abort = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("start_abort_idle", int'(a_busy), 0);
    end
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      stall = $urandom_range(0, 4) == 0;
      abort = $urandom_range(0, 59) == 0;
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
